muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with HI/LO result registers for the 5-stage MIPS pipeline. It sits in the EXE stage beside the ALU and executes MULT/MULTU/DIV/DIVU over multiple cycles. While running it raises busy, which the hazard detection unit uses to stall IF/ID/EXE. It also services MTHI/MTLO writes, and its hi/lo outputs feed the MFHI/MFLO path.

Parameters:
WIDTH, 32, operand and HI/LO width in bits; must be ≥4 and even.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  in  1  pipeline clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset (asserted when 0).
start  in  1  request from EXE stage; sampled on a rising edge.
op  in  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO (package encodings).
a  in  WIDTH  rs operand, after forwarding.
b  in  WIDTH  rt operand, after forwarding.
flush  in  1  cancels any in-flight operation (branch/jump flush of EXE).
busy  out  1  high while an iterative operation runs.
done  out  1  single-cycle pulse when hi/lo take a MULT/DIV result.
div_by_zero  out  1  pulses together with done when a divide had b==0.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; hi=lo=0; busy=done=div_by_zero=0; counter=0.
- States: IDLE, RUN, FIN.
- In IDLE or FIN, start=1 with flush=0 accepts the request. a, b, op are captured at that edge; later changes to the inputs have no effect.
- In RUN, start is ignored (no queueing).
- MTHI/MTLO: hi (or lo) <= a at the accepting edge. State goes to IDLE. busy and done stay low.
- MULT/MULTU/DIV/DIVU with b≠0 (or any multiply):
  - The accepting edge enters RUN.
  - busy is high for exactly WIDTH cycles.
  - The edge ending the last RUN cycle writes hi/lo and enters FIN.
  - done=1 for the single FIN cycle. FIN goes to IDLE unless a new start is accepted.
- Multiply: radix-2 shift-add on magnitudes, one bit per cycle, 2*WIDTH-bit product.
  - Signed ops negate the product when the operand signs differ.
  - hi = upper WIDTH bits, lo = lower WIDTH bits.
- Divide: restoring, one quotient bit per cycle, on magnitudes.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - lo = quotient, hi = remainder.
- Signed overflow (DIV with MIN / -1): lo = MIN (0x80..0), hi = 0. No flag is raised.
- Divide by zero (DIV or DIVU with b==0): no RUN phase; the accepting edge enters FIN directly.
  - lo = all ones, hi = a.
  - done=1 and div_by_zero=1 for that FIN cycle; busy never rises.
- flush=1 in RUN: the next edge returns to IDLE. hi/lo are unchanged, and no done or div_by_zero is produced.
- flush=1 in FIN: done still shows for that cycle (the result is already committed); the next state is IDLE.
- flush and start on the same edge: flush wins; nothing is accepted and MTHI/MTLO do not write.
- Back-to-back: start during FIN is accepted. done is high in FIN, and busy rises on the following cycle.
- Reset asserted mid-RUN: the operation is abandoned immediately and outputs take their reset values.
- Width rules: the counter counts WIDTH down to 1. Magnitude negation uses WIDTH+1 bits internally so that MIN is correct.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: MULT=3'd0, MULTU=3'd1, DIV=3'd2, DIVU=3'd3, MTHI=3'd4, MTLO=3'd5, others = no-op;
  - state enum {IDLE, RUN, FIN};
  - a function giving the two's-complement magnitude.
- One sub-module, muldiv_step: combinational single-iteration datapath.
  - Multiply mode: conditional add and shift.
  - Divide mode: trial subtract, restore, shift in the quotient bit.
  - The muldiv_unit FSM registers its accumulator/quotient each RUN cycle.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 32 cycles, then done for 1 cycle; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIVU a=100 b=7 -> lo=14, hi=2.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU a=5 b=0 -> busy stays 0; next cycle done=1 and div_by_zero=1; lo=0xFFFFFFFF, hi=5.
- MTHI a=0x12, then MTLO a=0x34, then MULT 9*9 with flush on RUN cycle 10 -> no done; hi=0x12, lo=0x34; busy low the cycle after flush. A start pulsed mid-RUN is ignored.
- Reset low in RUN cycle 5 of DIV -> all outputs 0 without waiting for clk. After release, MULTU 6*7 -> lo=42, hi=0 after 32 busy cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
// Operand magnitudes are formed at MAG_W+1 bits so the most negative value is exact.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MAG_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    function automatic logic [MAG_W:0] magnitude(input logic [MAG_W:0] value, input logic isSigned);
        logic [MAG_W:0] result;
        if (isSigned && value[MAG_W]) begin
            result = -value;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply,
// trial-subtract/restore for divide, operating on the {accHi, accLo} pair.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] accHi,
    input  logic [WIDTH-1:0] accLo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nextHi,
    output logic [WIDTH-1:0] nextLo
);

    logic [WIDTH:0]   addend_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH-1:0] diff_s;
    logic             fits_s;

    // Single multiply or divide iteration selected by isDiv.
    always_comb begin
        addend_s  = accLo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}};
        sum_s     = {1'b0, accHi} + addend_s;
        // Partial remainder is always below the divisor, so the shifted value fits WIDTH+1 bits.
        shifted_s = {accHi, accLo[WIDTH-1]};
        diff_s    = WIDTH'(shifted_s - {1'b0, operand});
        fits_s    = (shifted_s >= {1'b0, operand});
        if (isDiv) begin
            nextHi = fits_s ? diff_s : shifted_s[WIDTH-1:0];
            nextLo = {accLo[WIDTH-2:0], fits_s};
        end else begin
            nextHi = sum_s[WIDTH:1];
            nextLo = {sum_s[0], accLo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the EXE stage.
// Runs on operand magnitudes for WIDTH cycles and fixes signs when committing.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state_r,    stateNext_s;
    logic [CNT_W-1:0]   cnt_r,      cntNext_s;
    logic [WIDTH-1:0]   accHi_r,    accHiNext_s;
    logic [WIDTH-1:0]   accLo_r,    accLoNext_s;
    logic [WIDTH-1:0]   operand_r,  operandNext_s;
    logic               isDiv_r,    isDivNext_s;
    logic               negA_r,     negANext_s;
    logic               negB_r,     negBNext_s;
    logic [WIDTH-1:0]   hi_r,       hiNext_s;
    logic [WIDTH-1:0]   lo_r,       loNext_s;
    logic               busy_r,     busyNext_s;
    logic               done_r,     doneNext_s;
    logic               dbz_r,      dbzNext_s;

    logic               signedOp_s;
    logic [WIDTH-1:0]   aMag_s;
    logic [WIDTH-1:0]   bMag_s;
    logic [WIDTH-1:0]   stepHi_s;
    logic [WIDTH-1:0]   stepLo_s;
    logic [2*WIDTH-1:0] rawProd_s;
    logic [2*WIDTH-1:0] product_s;
    logic [WIDTH-1:0]   quotient_s;
    logic [WIDTH-1:0]   remainder_s;

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

    assign signedOp_s = (op == OP_MULT) || (op == OP_DIV);
    assign aMag_s = WIDTH'(magnitude({{(MAG_W+1-WIDTH){signedOp_s & a[WIDTH-1]}}, a}, signedOp_s));
    assign bMag_s = WIDTH'(magnitude({{(MAG_W+1-WIDTH){signedOp_s & b[WIDTH-1]}}, b}, signedOp_s));

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .isDiv  (isDiv_r),
        .accHi  (accHi_r),
        .accLo  (accLo_r),
        .operand(operand_r),
        .nextHi (stepHi_s),
        .nextLo (stepLo_s)
    );

    // Sign fix-up on the final iteration; MIN / -1 wraps naturally to MIN with remainder 0.
    assign rawProd_s   = {stepHi_s, stepLo_s};
    assign product_s   = (negA_r ^ negB_r) ? -rawProd_s : rawProd_s;
    assign quotient_s  = (negA_r ^ negB_r) ? -stepLo_s : stepLo_s;
    assign remainder_s = negA_r ? -stepHi_s : stepHi_s;

    // Next-state and next-output logic for the IDLE/RUN/FIN controller.
    always_comb begin
        stateNext_s   = state_r;
        cntNext_s     = cnt_r;
        accHiNext_s   = accHi_r;
        accLoNext_s   = accLo_r;
        operandNext_s = operand_r;
        isDivNext_s   = isDiv_r;
        negANext_s    = negA_r;
        negBNext_s    = negB_r;
        hiNext_s      = hi_r;
        loNext_s      = lo_r;
        doneNext_s    = 1'b0;
        dbzNext_s     = 1'b0;
        case (state_r)
            IDLE, FIN: begin
                stateNext_s = IDLE;
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            if (op[1] && (b == {WIDTH{1'b0}})) begin
                                stateNext_s = FIN;
                                hiNext_s    = a;
                                loNext_s    = {WIDTH{1'b1}};
                                doneNext_s  = 1'b1;
                                dbzNext_s   = 1'b1;
                            end else begin
                                stateNext_s   = RUN;
                                cntNext_s     = CNT_W'(WIDTH);
                                accHiNext_s   = {WIDTH{1'b0}};
                                accLoNext_s   = aMag_s;
                                operandNext_s = bMag_s;
                                isDivNext_s   = op[1];
                                negANext_s    = signedOp_s & a[WIDTH-1];
                                negBNext_s    = signedOp_s & b[WIDTH-1];
                            end
                        end
                        OP_MTHI: hiNext_s = a;
                        OP_MTLO: loNext_s = a;
                        default: stateNext_s = IDLE;
                    endcase
                end else begin
                    stateNext_s = IDLE;
                end
            end
            RUN: begin
                if (flush) begin
                    stateNext_s = IDLE;
                end else begin
                    accHiNext_s = stepHi_s;
                    accLoNext_s = stepLo_s;
                    cntNext_s   = cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        stateNext_s = FIN;
                        doneNext_s  = 1'b1;
                        if (isDiv_r) begin
                            hiNext_s = remainder_s;
                            loNext_s = quotient_s;
                        end else begin
                            hiNext_s = product_s[2*WIDTH-1:WIDTH];
                            loNext_s = product_s[WIDTH-1:0];
                        end
                    end else begin
                        stateNext_s = RUN;
                    end
                end
            end
            default: stateNext_s = IDLE;
        endcase
        busyNext_s = (stateNext_s == RUN);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            accHi_r   <= {WIDTH{1'b0}};
            accLo_r   <= {WIDTH{1'b0}};
            operand_r <= {WIDTH{1'b0}};
            isDiv_r   <= 1'b0;
            negA_r    <= 1'b0;
            negB_r    <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dbz_r     <= 1'b0;
        end else begin
            state_r   <= stateNext_s;
            cnt_r     <= cntNext_s;
            accHi_r   <= accHiNext_s;
            accLo_r   <= accLoNext_s;
            operand_r <= operandNext_s;
            isDiv_r   <= isDivNext_s;
            negA_r    <= negANext_s;
            negB_r    <= negBNext_s;
            hi_r      <= hiNext_s;
            lo_r      <= loNext_s;
            busy_r    <= busyNext_s;
            done_r    <= doneNext_s;
            dbz_r     <= dbzNext_s;
        end
    end

endmodule
